// File: rtl/data_bus_slave_if.sv
// Data-memory bus bundle between the core's ram_* port and data_bus_slave.
// Latency: none, this is wiring only.
// Backpressure: none; the bus has no stall, every access completes in its cycle.
// Signals: ce_i/we_i/addr_i/sel_i/data_i are driven by the master.
// data_o/bus_err_o/timer_int_o are driven by the slave.
interface data_bus_slave_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        bus_err_o;
  logic        timer_int_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, bus_err_o, timer_int_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, bus_err_o, timer_int_o
  );
endinterface

// File: rtl/data_bus_slave.sv
// Data-bus responder: byte-lane-writable word RAM plus a memory-mapped 64-bit machine timer.
// Latency: reads and bus_err_o are combinational; writes commit on the clk edge; timer_int_o is 1 cycle after the compare.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: clk, rst (synchronous, active-low), bus (data_bus_slave_if.slave).
// Optional macro DBUS_TIMER_PRESC_EN adds the 8-bit mtime prescaler held in ctrl[15:8].
module data_bus_slave #(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] MMIO_BASE = 16'h0200,
  parameter logic [3:0]  RAM_BASE  = 4'h0
) (
  input logic             clk,
  input logic             rst,
  data_bus_slave_if.slave bus
);

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = wdat[8*k +: 8];
    end
    return res;
  endfunction

  // MMIO_BASE lies inside the RAM nibble with the default parameters, so the
  // narrower timer window takes precedence over RAM aliasing.
  logic mmio_hit;
  logic ram_hit;
  assign mmio_hit = (bus.addr_i[31:16] == MMIO_BASE);
  assign ram_hit  = !mmio_hit && (bus.addr_i[31:28] == RAM_BASE);

  logic [2:0]        reg_sel;
  logic [RAM_AW-1:0] word_idx;
  assign reg_sel  = bus.addr_i[4:2];
  assign word_idx = bus.addr_i[RAM_AW+1:2];

  // An all-zero sel_i is a no-op everywhere, including the mtime override
  // and the prescaler restart.
  logic wr_en;
  logic ram_wr;
  logic mmio_wr;
  assign wr_en   = rst && bus.ce_i && bus.we_i && (bus.sel_i != 4'h0);
  assign ram_wr  = wr_en && ram_hit;
  assign mmio_wr = wr_en && mmio_hit;

  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  assign wr_mtime_lo = mmio_wr && (reg_sel == 3'd0);
  assign wr_mtime_hi = mmio_wr && (reg_sel == 3'd1);
  assign wr_cmp_lo   = mmio_wr && (reg_sel == 3'd2);
  assign wr_cmp_hi   = mmio_wr && (reg_sel == 3'd3);
  assign wr_ctrl     = mmio_wr && (reg_sel == 3'd4);

  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.sel_i[k]) mem[word_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
      end
    end
  end

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        en_q;
  logic        mask_q;
  logic        timer_int_q;
  logic [7:0]  presc;
  logic        tick;
  logic        cmp_ge;
  logic [31:0] ctrl_rd;
  logic [31:0] ctrl_wdat;

  assign cmp_ge    = (mtime_q >= mtimecmp_q);
  assign ctrl_rd   = {16'h0000, presc, 6'b000000, mask_q, en_q};
  assign ctrl_wdat = merge_lanes(ctrl_rd, bus.data_i, bus.sel_i);

`ifdef DBUS_TIMER_PRESC_EN
  logic [7:0] presc_q;
  logic [7:0] pcnt_q;
  assign presc = presc_q;
  assign tick  = en_q && (pcnt_q == presc_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= 8'h00;
      pcnt_q  <= 8'h00;
    end else begin
      if (wr_ctrl) presc_q <= ctrl_wdat[15:8];
      if (wr_ctrl || !en_q || tick) pcnt_q <= 8'h00;
      else                          pcnt_q <= pcnt_q + 8'd1;
    end
  end
`else
  assign presc = 8'h00;
  assign tick  = en_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q        <= 1'b0;
      mask_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      timer_int_q <= en_q && mask_q && cmp_ge;
      // A software write to either half freezes the whole counter for this edge.
      if (wr_mtime_lo)
        mtime_q[31:0] <= merge_lanes(mtime_q[31:0], bus.data_i, bus.sel_i);
      else if (wr_mtime_hi)
        mtime_q[63:32] <= merge_lanes(mtime_q[63:32], bus.data_i, bus.sel_i);
      else if (tick)
        mtime_q <= mtime_q + 64'd1;
      if (wr_cmp_lo)
        mtimecmp_q[31:0] <= merge_lanes(mtimecmp_q[31:0], bus.data_i, bus.sel_i);
      if (wr_cmp_hi)
        mtimecmp_q[63:32] <= merge_lanes(mtimecmp_q[63:32], bus.data_i, bus.sel_i);
      if (wr_ctrl) begin
        en_q   <= ctrl_wdat[0];
        mask_q <= ctrl_wdat[1];
      end
    end
  end

  logic [31:0] rd_dat;
  always_comb begin
    rd_dat = 32'h0;
    if (mmio_hit) begin
      case (reg_sel)
        3'd0:    rd_dat = mtime_q[31:0];
        3'd1:    rd_dat = mtime_q[63:32];
        3'd2:    rd_dat = mtimecmp_q[31:0];
        3'd3:    rd_dat = mtimecmp_q[63:32];
        3'd4:    rd_dat = ctrl_rd;
        3'd5:    rd_dat = {31'h0, cmp_ge};
        default: rd_dat = 32'h0;
      endcase
    end else if (ram_hit) begin
      rd_dat = mem[word_idx];
    end
  end

  assign bus.data_o      = (bus.ce_i && !bus.we_i) ? rd_dat : 32'h0;
  assign bus.bus_err_o   = bus.ce_i && !mmio_hit && !ram_hit;
  assign bus.timer_int_o = timer_int_q;

  // Address bits that only alias, and ctrl bits with no storage.
  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[15:5], bus.addr_i[1:0], ctrl_wdat[31:2]};

endmodule

// File: tb/tb_data_bus_slave.sv
// Self-checking bench for data_bus_slave: directed table, hand sequences, random traffic vs a reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: not applicable.
module tb_data_bus_slave;

  localparam logic [31:0] MT_LO  = 32'h0200_0000;
  localparam logic [31:0] MT_HI  = 32'h0200_0004;
  localparam logic [31:0] CMP_LO = 32'h0200_0008;
  localparam logic [31:0] CMP_HI = 32'h0200_000C;
  localparam logic [31:0] CTRL   = 32'h0200_0010;
  localparam logic [31:0] STAT   = 32'h0200_0014;
`ifdef DBUS_TIMER_PRESC_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
  localparam logic [31:0] PRESC_CTRL_RB = 32'h0000_0301;
  localparam logic [31:0] PRESC_MTIME   = 32'd4;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_0003;
  localparam logic [31:0] PRESC_CTRL_RB = 32'h0000_0001;
  localparam logic [31:0] PRESC_MTIME   = 32'd16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_bus_slave_if bus ();

  data_bus_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  logic [63:0] m_mtime = 64'h0;
  logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0] m_ctrl  = 32'h0;
  int          m_pcnt  = 0;
  logic        m_irq   = 1'b0;
  logic [31:0] m_mem   [0:1023];
  bit          m_known [0:1023];

  logic [31:0] s_data;
  logic        s_err;
  logic        s_int;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'h0200;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return !is_mmio(a) && a[31:28] == 4'h0;
  endfunction

  // Expected read data; 'known' is 0 when the RAM word was never fully written.
  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic err,
                            output bit known);
    known = 1;
    err   = 0;
    d     = 32'h0;
    if (is_mmio(a)) begin
      case (int'(a[4:2]))
        0: d = m_mtime[31:0];
        1: d = m_mtime[63:32];
        2: d = m_cmp[31:0];
        3: d = m_cmp[63:32];
        4: d = m_ctrl;
        5: d = {31'h0, (m_mtime >= m_cmp)};
        default: d = 32'h0;
      endcase
    end else if (is_ram(a)) begin
      d     = m_mem[a[11:2]];
      known = m_known[a[11:2]];
    end else begin
      err = 1;
    end
  endtask

  task automatic model_edge(input logic rv, input logic ce, input logic we,
                            input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit wr, tick, mt_written, ctrl_written, en;
    logic nirq;
    if (!rv) begin
      m_mtime = 64'h0; m_cmp = '1; m_ctrl = 32'h0; m_pcnt = 0; m_irq = 1'b0;
      return;
    end
    en   = m_ctrl[0];
    nirq = m_ctrl[0] & m_ctrl[1] & (m_mtime >= m_cmp);
`ifdef DBUS_TIMER_PRESC_EN
    tick = en && (m_pcnt == int'(m_ctrl[15:8]));
`else
    tick = en;
`endif
    wr = ce && we && (s != 4'h0);
    mt_written = 0;
    ctrl_written = 0;
    if (wr && is_mmio(a)) begin
      case (int'(a[4:2]))
        0: begin m_mtime[31:0]  = lanes(m_mtime[31:0], d, s);  mt_written = 1; end
        1: begin m_mtime[63:32] = lanes(m_mtime[63:32], d, s); mt_written = 1; end
        2: m_cmp[31:0]  = lanes(m_cmp[31:0], d, s);
        3: m_cmp[63:32] = lanes(m_cmp[63:32], d, s);
        4: begin m_ctrl = lanes(m_ctrl, d, s) & CTRL_MASK; ctrl_written = 1; end
        default: ;
      endcase
    end else if (wr && is_ram(a)) begin
      m_mem[a[11:2]] = lanes(m_mem[a[11:2]], d, s);
      if (s == 4'hF) m_known[a[11:2]] = 1;
    end
    if (!mt_written && tick) m_mtime = m_mtime + 64'd1;
    if (ctrl_written || !en || tick) m_pcnt = 0;
    else                             m_pcnt = m_pcnt + 1;
    m_irq = nirq;
  endtask

  // One bus cycle: drive, sample at negedge against the model, step the model at posedge.
  task automatic cycle(input logic rv, input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    logic [31:0] ed;
    logic ee;
    bit kn;
    rst = rv; bus.ce_i = ce; bus.we_i = we; bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
    @(negedge clk);
    model_read(a, ed, ee, kn);
    if (!ce) begin ed = 32'h0; ee = 1'b0; end
    if (we)  ed = 32'h0;
    s_data = bus.data_o;
    s_err  = bus.bus_err_o;
    s_int  = bus.timer_int_o;
    if (kn || !ce || we) check("model_data", s_data, ed);
    check("model_err", {31'h0, s_err}, {31'h0, ee});
    check("model_int", {31'h0, s_int}, {31'h0, m_irq});
    @(posedge clk);
    model_edge(rv, ce, we, a, s, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cycle(1'b1, 1'b1, 1'b1, a, s, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h3000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 32'h0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0FFF_F010, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, MT_LO,         4'h0, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, MT_HI,         4'h0, 32'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, CMP_LO,        4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0200_0FEC, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    tbl[11] = '{1'b1, 1'b0, CTRL,          4'h0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, STAT,          4'h0, 32'h0, 32'h0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h0200_0018, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, STAT,          4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, STAT,          4'h0, 32'h0, 32'h0, 1'b0};

    for (int i = 0; i < 1024; i++) begin m_mem[i] = 32'h0; m_known[i] = 0; end

    // Reset: two edges with rst low, model already holds reset values.
    rst = 1'b0; bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h0;
    bus.sel_i = 4'h0; bus.data_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data);
      check($sformatf("tbl%0d_data", i), s_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_err", i), {31'h0, s_err}, {31'h0, tbl[i].exp_err});
      check($sformatf("tbl%0d_int", i), {31'h0, s_int}, 32'h0);
    end

    // Lo-to-hi carry
    wr(MT_LO, 32'hFFFF_FFFE, 4'hF);
    wr(MT_HI, 32'h0, 4'hF);
    wr(CTRL, 32'h1, 4'hF);
    idle(); idle();
    rd(MT_LO); check("carry_lo", s_data, 32'h0);
    rd(MT_HI); check("carry_hi", s_data, 32'h1);

    // 64-bit wrap; the hi write also must not bump lo
    wr(MT_LO, 32'hFFFF_FFFF, 4'hF);
    wr(MT_HI, 32'hFFFF_FFFF, 4'hF);
    rd(MT_LO); check("wrap_pre_lo", s_data, 32'hFFFF_FFFF);
    rd(MT_HI); check("wrap_hi", s_data, 32'h0);
    rd(MT_LO); check("wrap_lo", s_data, 32'h1);

    // Interrupt rise timing
    wr(CTRL, 32'h0, 4'hF);
    wr(CMP_LO, 32'd20, 4'hF);
    wr(CMP_HI, 32'h0, 4'hF);
    wr(MT_LO, 32'h0, 4'hF);
    wr(MT_HI, 32'h0, 4'hF);
    wr(CTRL, 32'h3, 4'hF);
    for (int k = 1; k <= 25; k++) begin
      idle();
      check($sformatf("irq_rise_k%0d", k), {31'h0, s_int}, (k >= 22) ? 32'h1 : 32'h0);
    end
    wr(CMP_LO, 32'd100, 4'hF);
    idle(); idle();
    check("irq_clear_cmp", {31'h0, s_int}, 32'h0);
    wr(CTRL, 32'h1, 4'hF);
    wr(CMP_LO, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("irq_masked", {31'h0, s_int}, 32'h0);
    end

    // Write/tick collision
    wr(MT_LO, 32'h1234_5600, 4'hF);
    idle();
    wr(MT_LO, 32'h0000_0005, 4'h1);
    rd(MT_LO); check("collision_lo", s_data, 32'h1234_5605);

    // Reset mid-count with interrupt asserted
    wr(CTRL, 32'h3, 4'hF);
    wr(CMP_LO, 32'h0, 4'hF);
    wr(CMP_HI, 32'h0, 4'hF);
    idle(); idle();
    check("irq_before_rst", {31'h0, s_int}, 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
    rd(MT_LO);  check("rst_mtime_lo", s_data, 32'h0);
    check("rst_int", {31'h0, s_int}, 32'h0);
    rd(MT_HI);  check("rst_mtime_hi", s_data, 32'h0);
    rd(CMP_LO); check("rst_cmp_lo", s_data, 32'hFFFF_FFFF);
    rd(CMP_HI); check("rst_cmp_hi", s_data, 32'hFFFF_FFFF);
    rd(CTRL);   check("rst_ctrl", s_data, 32'h0);
    rd(32'h0000_0010); check("rst_ram_kept", s_data, 32'hAA22_CC44);

    // Prescale field
    wr(CTRL, 32'h0000_0301, 4'hF);
    rd(CTRL); check("presc_ctrl_rb", s_data, PRESC_CTRL_RB);
    for (int k = 0; k < 15; k++) idle();
    rd(MT_LO); check("presc_mtime", s_data, PRESC_MTIME);

    // Random traffic against the model
    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4)
        a = {4'h0, 16'($urandom), 6'b0, 4'($urandom), 2'($urandom)};
      else if (kind < 8)
        a = {16'h0200, 11'($urandom), 3'($urandom), 2'($urandom)};
      else
        a = {4'($urandom_range(1, 15)), 28'($urandom)};
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      cycle(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), a, 4'($urandom), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
